// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and deglitches the raw lines, deframes
// bytes, and folds E0/F0/E1 prefixes into the 11-bit ps2_key event word.
module ps2_key_decoder #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int FW = (FILTER < 2) ? 1 : $clog2(FILTER);
  localparam int TW = ($clog2(TIMEOUT + 1) > 16) ? $clog2(TIMEOUT + 1) : 16;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Index 0 carries the clock line, index 1 the data line.
  logic [1:0]    sync1_q, sync2_q, filt_q;
  logic [FW-1:0] cnt_q [2];
  logic          clk_prev_q;

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shreg_q;
  logic [7:0]    shreg_d;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          ext_q, rel_q;
  logic [2:0]    skip_q;
  logic [10:0]   key_q;
  logic          err_q;

  logic clk_fall, dat_f;

  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      filt_q     <= '1;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
      clk_prev_q <= 1'b1;
    end else begin
      sync1_q    <= {ps2_dat, ps2_clk};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (cnt_q[i] == FW'(FILTER - 1)) begin
            filt_q[i] <= sync2_q[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // The falling edge is seen one cycle after the filtered clock drops.
  assign clk_fall = clk_prev_q & ~filt_q[0];
  assign dat_f    = filt_q[1];
  assign shreg_d  = {dat_f, shreg_q[7:1]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tmo_q    <= '0;
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      skip_q   <= '0;
      key_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (clk_fall) begin
        tmo_q <= '0;
        case (state_q)
          S_IDLE: begin
            if (!dat_f) begin
              state_q  <= S_DATA;
              bitcnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_DATA: begin
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_f;
            state_q <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            if (dat_f && (^{shreg_q, par_q})) begin
              if (skip_q != 3'd0) begin
                skip_q <= skip_q - 1'b1;
              end else if (shreg_q == 8'hE1) begin
                skip_q <= 3'd7;  // rest of the Pause sequence carries no key
              end else if (shreg_q == 8'hE0) begin
                ext_q <= 1'b1;
              end else if (shreg_q == 8'hF0) begin
                rel_q <= 1'b1;
              end else begin
                key_q <= {~key_q[10], ~rel_q, ext_q, shreg_q};
                ext_q <= 1'b0;
                rel_q <= 1'b0;
              end
            end else begin
              err_q <= 1'b1;
              ext_q <= 1'b0;
              rel_q <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q != S_IDLE) begin
        if (tmo_q == TW'(TIMEOUT)) begin
          state_q  <= S_IDLE;
          bitcnt_q <= '0;
          shreg_q  <= '0;
          tmo_q    <= '0;
          err_q    <= 1'b1;
          ext_q    <= 1'b0;
          rel_q    <= 1'b0;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign ps2_key = key_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames bit by bit and compares each
// event/error against a byte-level model of the prefix rules.
module tb_ps2_key_decoder;

  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        err;

  ps2_key_decoder #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .ps2_key (ps2_key),
    .err     (err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  // Byte-level model state
  logic        m_tog = 1'b0, m_ext = 1'b0, m_rel = 1'b0;
  int          m_skip = 0;
  logic [10:0] exp_q[$];
  int          exp_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      m_tog = ~m_tog;
      exp_q.push_back({m_tog, ~m_rel, m_ext, b});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic model_err();
    exp_err++;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_sys);
  endtask

  // Sends the first nbits of a frame; bad_par inverts the odd-parity bit.
  task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      cycles(15);
      ps2_clk = 1'b0;
      cycles(20);
      ps2_clk = 1'b1;
      cycles(15);
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits(b, 1'b0, 11);
    cycles(20);
  endtask

  task automatic drained(input string name);
    cycles(40);
    check({name, "_events_left"}, exp_q.size(), 0);
    check({name, "_errs_left"}, exp_err, 0);
  endtask

  // Per-cycle compare against the model
  logic [10:0] prev_key;
  logic        prev_err;
  always @(negedge clk_sys) begin
    if (reset) begin
      prev_key = ps2_key;
      prev_err = err;
    end else begin
      if (ps2_key !== prev_key) begin
        if (exp_q.size() == 0) check("spurious_event", ps2_key, prev_key);
        else check("event", ps2_key, exp_q.pop_front());
        check("err_with_event", err, 0);
      end
      if (err) begin
        check("err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
        check("err_one_cycle", prev_err, 0);
      end
      prev_key = ps2_key;
      prev_err = err;
    end
  end

  initial begin
    cycles(5);
    reset = 1'b0;
    @(negedge clk_sys);
    check("reset_key", ps2_key, 11'h000);
    check("reset_err", err, 0);
    cycles(20);

    // Plain make code
    send_byte(8'h1C);
    check("key_1c", ps2_key, 11'h61C);
    drained("make");

    // Extended break: one event only
    send_byte(8'hE0);
    check("no_event_after_e0", ps2_key, 11'h61C);
    send_byte(8'hF0);
    check("no_event_after_f0", ps2_key, 11'h61C);
    send_byte(8'h6B);
    check("key_e0_f0_6b", ps2_key, 11'h16B);
    drained("ext_break");

    // Parity error clears a pending release prefix
    send_byte(8'hF0);
    model_err();
    send_bits(8'h29, 1'b1, 11);
    cycles(20);
    check("bad_parity_no_event", ps2_key, 11'h16B);
    send_byte(8'h29);
    check("key_29_pressed", ps2_key, 11'h629);
    send_byte(8'hF0);
    send_byte(8'h29);
    check("key_29_released", ps2_key, 11'h029);
    drained("parity");

    // Timeout on a partial frame
    model_err();
    send_bits(8'h55, 1'b0, 6);
    cycles(TIMEOUT + 10);
    check("timeout_no_event", ps2_key, 11'h029);
    send_byte(8'h16);
    check("key_16", ps2_key, 11'h616);
    drained("timeout");

    // Pause sequence is swallowed
    send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
    send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
    check("pause_no_event", ps2_key, 11'h616);
    send_byte(8'h5A);
    check("key_5a", ps2_key, 11'h25A);
    drained("pause");

    // Short clock glitch is filtered out
    ps2_clk = 1'b0;
    cycles(2);
    ps2_clk = 1'b1;
    cycles(40);
    check("glitch_no_event", ps2_key, 11'h25A);
    drained("glitch");

    // Reset mid-frame, then a clean frame
    send_bits(8'h1C, 1'b0, 4);
    reset = 1'b1;
    cycles(3);
    m_tog = 1'b0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
    reset = 1'b0;
    @(negedge clk_sys);
    check("midframe_reset_key", ps2_key, 11'h000);
    cycles(20);
    send_byte(8'h1C);
    check("key_1c_after_reset", ps2_key, 11'h61C);
    drained("reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
